// File: rtl/gates_rr_scheduler_if.sv
// Bundle of requester, result and shared-unit signals for gates_rr_scheduler.
// The master side is the requesters plus the shared AND unit. The slave side is the scheduler.
interface gates_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      y1;
  logic              y2;
  logic [W-1:0]      gu_a;
  logic [W-1:0]      gu_b;
  logic [W-1:0]      gu_y1;
  logic              gu_y2;
  logic              busy;
  logic              err;

  modport master (
    output req, a_in, b_in, gu_y1, gu_y2,
    input  gnt, done, y1, y2, gu_a, gu_b, busy, err
  );

  modport slave (
    input  req, a_in, b_in, gu_y1, gu_y2,
    output gnt, done, y1, y2, gu_a, gu_b, busy, err
  );
endinterface

// File: rtl/gates_rr_scheduler.sv
// Round-robin scheduler sharing one bitwise/reduction AND unit among NREQ requesters.
// A three-state FSM (IDLE, EXEC, RESP) runs the sequence arbitrate, execute, respond, and checks the unit's results.
module gates_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  gates_rr_scheduler_if.slave  bus
);
  localparam int            PW     = $clog2(NREQ);
  localparam logic [PW:0]   NREQ_L = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST   = PW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [W-1:0]      y1_q, y1_d;
  logic              y2_q, y2_d;
  logic [W-1:0]      gu_a_q, gu_a_d;
  logic [W-1:0]      gu_b_q, gu_b_d;
  logic              err_q, err_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;

  logic [PW:0]       cand;
  logic [PW-1:0]     win_idx;
  logic              win_vld;

  // Scan from the highest offset down so the last hit is the one closest to ptr.
  always_comb begin
    cand    = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= NREQ_L) cand = cand - NREQ_L;
      if (bus.req[cand[PW-1:0]]) begin
        win_idx = cand[PW-1:0];
        win_vld = 1'b1;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = done_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    gu_a_d  = gu_a_q;
    gu_b_d  = gu_b_q;
    err_d   = err_q;
    ptr_d   = ptr_q;
    win_d   = win_q;

    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          gu_a_d  = bus.a_in[win_idx*W +: W];
          gu_b_d  = bus.b_in[win_idx*W +: W];
          gnt_d   = NREQ'(1) << win_idx;
          win_d   = win_idx;
          ptr_d   = (win_idx == LAST) ? '0 : win_idx + 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        y1_d    = bus.gu_y1;
        y2_d    = bus.gu_y2;
        done_d  = NREQ'(1) << win_q;
        gnt_d   = '0;
        state_d = RESP;
        if ((bus.gu_y1 != (gu_a_q & gu_b_q)) || (bus.gu_y2 != &gu_a_q)) err_d = 1'b1;
      end
      RESP: begin
        done_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with the control state, because their reset values are visible on the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      y1_q    <= '0;
      y2_q    <= 1'b0;
      gu_a_q  <= '0;
      gu_b_q  <= '0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the pre-edge values.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      gu_a_q  <= gu_a_d;
      gu_b_q  <= gu_b_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.y1   = y1_q;
  assign bus.y2   = y2_q;
  assign bus.gu_a = gu_a_q;
  assign bus.gu_b = gu_b_q;
  assign bus.err  = err_q;
  assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_gates_rr_scheduler.sv
// Directed bench for gates_rr_scheduler: a table of single operations, then sequences for held requests, a faulty unit and reset.
module tb_gates_rr_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 4;

  logic clk = 1'b0;
  logic reset;
  logic fault;
  int   total = 0;
  int   bad   = 0;
  logic exp_err;

  gates_rr_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

  gates_rr_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Shared gates unit model. fault forces a wrong bitwise result.
  assign bus.gu_y1 = fault ? '0 : (bus.gu_a & bus.gu_b);
  assign bus.gu_y2 = &bus.gu_a;

  typedef struct {
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a;
    logic [NREQ*W-1:0] b;
    logic [NREQ-1:0]   exp_gnt;
    logic [W-1:0]      exp_gu_a;
    logic [W-1:0]      exp_gu_b;
    logic [W-1:0]      exp_y1;
    logic              exp_y2;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.req   = '0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    tick();
    tick();
    reset   = 1'b0;
    exp_err = 1'b0;
  endtask

  // One full operation, starting in IDLE. Operands are scrambled after the grant to prove they were captured.
  task automatic run_op(input vec_t v, input string tag);
    bus.req  = v.req;
    bus.a_in = v.a;
    bus.b_in = v.b;
    tick();
    check({tag, ".gnt"},  bus.gnt,  v.exp_gnt);
    check({tag, ".busy"}, bus.busy, 1);
    check({tag, ".gu_a"}, bus.gu_a, v.exp_gu_a);
    check({tag, ".gu_b"}, bus.gu_b, v.exp_gu_b);
    check({tag, ".done0"}, bus.done, 0);
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    tick();
    check({tag, ".done"}, bus.done, v.exp_gnt);
    check({tag, ".gnt0"}, bus.gnt,  0);
    check({tag, ".y1"},   bus.y1,   v.exp_y1);
    check({tag, ".y2"},   bus.y2,   v.exp_y2);
    check({tag, ".err"},  bus.err,  exp_err);
    tick();
    check({tag, ".done_off"}, bus.done, 0);
    check({tag, ".idle"},     bus.busy, 0);
    check({tag, ".y1_hold"},  bus.y1,   v.exp_y1);
  endtask

  initial begin
    vec_t v;
    fault = 1'b0;

    // Requester i owns slice [i*W +: W]; the list reads {r3, r2, r1, r0}. ptr after each row: 2,1,3,0,1,0.
    vecs[0] = '{4'b0010, {4'hF,4'hF,4'h5,4'hF}, {4'hF,4'hF,4'hA,4'hF}, 4'b0010, 4'h5, 4'hA, 4'h0, 1'b0};
    vecs[1] = '{4'b0001, {4'h1,4'h2,4'h3,4'hF}, {4'h4,4'h5,4'h6,4'hA}, 4'b0001, 4'hF, 4'hA, 4'hA, 1'b1};
    vecs[2] = '{4'b1100, {4'hE,4'h3,4'h0,4'h0}, {4'h7,4'h6,4'hF,4'hF}, 4'b0100, 4'h3, 4'h6, 4'h2, 1'b0};
    vecs[3] = '{4'b1001, {4'hE,4'h0,4'h0,4'hB}, {4'h7,4'h0,4'h0,4'hD}, 4'b1000, 4'hE, 4'h7, 4'h6, 1'b0};
    vecs[4] = '{4'b1001, {4'hE,4'h0,4'h0,4'hB}, {4'h7,4'h0,4'h0,4'hD}, 4'b0001, 4'hB, 4'hD, 4'h9, 1'b0};
    vecs[5] = '{4'b1001, {4'hF,4'h0,4'h0,4'hB}, {4'hF,4'h0,4'h0,4'hD}, 4'b1000, 4'hF, 4'hF, 4'hF, 1'b1};

    // Reset state, and outputs staying put while idle.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      check("rst.gnt",  bus.gnt,  0);
      check("rst.done", bus.done, 0);
      check("rst.y1",   bus.y1,   0);
      check("rst.y2",   bus.y2,   0);
      check("rst.gu_a", bus.gu_a, 0);
      check("rst.busy", bus.busy, 0);
      check("rst.err",  bus.err,  0);
      tick();
    end

    for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // All requests held: grants rotate 0,1,2,3 three cycles apart.
    do_reset();
    bus.req  = 4'b1111;
    bus.a_in = '1;
    bus.b_in = '1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("held.gnt%0d", k),  bus.gnt,  (k % 3 == 0) ? (32'd1 << (k / 3)) : 32'd0);
      check($sformatf("held.done%0d", k), bus.done, (k % 3 == 1) ? (32'd1 << (k / 3)) : 32'd0);
      if (k % 3 == 1) begin
        check($sformatf("held.y1_%0d", k), bus.y1, 4'hF);
        check($sformatf("held.y2_%0d", k), bus.y2, 1);
      end
    end
    bus.req = '0;
    tick();

    // Faulty unit: done still issued, err set and sticky through a correct operation.
    do_reset();
    fault   = 1'b1;
    exp_err = 1'b1;
    v = '{4'b0001, {4'h0,4'h0,4'h0,4'hF}, {4'h0,4'h0,4'h0,4'hF}, 4'b0001, 4'hF, 4'hF, 4'h0, 1'b1};
    run_op(v, "fault");
    fault = 1'b0;
    v = '{4'b0010, {4'h0,4'h0,4'h3,4'h0}, {4'h0,4'h0,4'h5,4'h0}, 4'b0010, 4'h3, 4'h5, 4'h1, 1'b0};
    run_op(v, "sticky");

    // Reset during EXEC aborts the operation and clears err and ptr.
    bus.req  = 4'b0100;
    bus.a_in = '1;
    bus.b_in = '1;
    tick();
    check("abort.gnt", bus.gnt, 4'b0100);
    bus.req = '0;
    reset   = 1'b1;
    #1;
    check("abort.busy", bus.busy, 0);
    check("abort.gnt0", bus.gnt,  0);
    check("abort.err",  bus.err,  0);
    tick();
    reset   = 1'b0;
    exp_err = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("abort.no_done", bus.done, 0);
      tick();
    end
    v = '{4'b1111, {4'h1,4'h2,4'h3,4'h7}, {4'h8,4'h9,4'hA,4'hE}, 4'b0001, 4'h7, 4'hE, 4'h6, 1'b0};
    run_op(v, "ptr_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
